// File: rtl/soc_bus_fabric.sv
// Single-master bus fabric: tag-decoded slave regions, per-region read
// wait states, byte-lane swapping and a write-only console strobe.
module soc_bus_fabric #(
  parameter int                   NSLAVES      = 3,
  parameter logic [4*NSLAVES-1:0] SLV_TAG      = 12'he40,
  parameter logic [4*NSLAVES-1:0] SLV_WAIT     = 12'h111,
  parameter logic [NSLAVES-1:0]   SLV_SWAP     = 3'b100,
  parameter logic [31:0]          CONSOLE_ADDR = 32'hf00000d0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m_req_i,
  input  logic [31:0]             m_addr_i,
  input  logic [31:0]             m_wdata_i,
  input  logic [3:0]              m_we_i,
  output logic [31:0]             m_rdata_o,
  output logic                    m_ack_o,
  output logic                    err_o,
  output logic                    stall_o,
  output logic [NSLAVES-1:0]      s_sel_o,
  output logic [31:0]             s_addr_o,
  output logic [31:0]             s_wdata_o,
  output logic [3:0]              s_we_o,
  input  logic [32*NSLAVES-1:0]   s_rdata_i,
  output logic                    con_valid_o,
  output logic [7:0]              con_char_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [3:0] swap4(input logic [3:0] w);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  state_t               state, state_n;
  logic [31:0]          addr_q, wdata_q, rdata_q;
  logic [3:0]           we_q, cnt_q;
  logic [NSLAVES-1:0]   tgt_q;
  logic                 con_q, err_q, swap_q;

  logic [NSLAVES-1:0]   dec_sel;
  logic [3:0]           dec_wait;
  logic                 dec_swap, dec_con, dec_hit, take;
  logic [31:0]          slv_rd;
  logic                 is_wr, rd_done;

  assign dec_con = (m_addr_i == CONSOLE_ADDR);
  assign dec_hit = |dec_sel & ~dec_con;
  assign take    = (state == IDLE) & m_req_i;
  assign is_wr   = |we_q;
  assign rd_done = (state == ACCESS) & ~is_wr & (cnt_q == 4'd0);

  // Tag decode; scanning downward leaves the lowest matching index
  always_comb begin
    dec_sel  = '0;
    dec_wait = 4'd0;
    dec_swap = 1'b0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (m_addr_i[31:28] == SLV_TAG[4*i +: 4]) begin
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
        dec_wait   = SLV_WAIT[4*i +: 4];
        dec_swap   = SLV_SWAP[i];
      end
    end
  end

  // Read-data slice of the selected slave, zero when none is selected
  always_comb begin
    slv_rd = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (tgt_q[i]) slv_rd = slv_rd | s_rdata_i[32*i +: 32];
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (m_req_i) state_n = ACCESS;
      ACCESS:  if (is_wr || cnt_q == 4'd0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  // Request capture and wait-state countdown
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      tgt_q   <= '0;
      con_q   <= 1'b0;
      err_q   <= 1'b0;
      swap_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (take) begin
      addr_q  <= m_addr_i;
      wdata_q <= (dec_hit & dec_swap) ? swap32(m_wdata_i) : m_wdata_i;
      we_q    <= (dec_hit & dec_swap) ? swap4(m_we_i) : m_we_i;
      tgt_q   <= dec_hit ? dec_sel : '0;
      con_q   <= dec_con & (|m_we_i);
      err_q   <= ~dec_con & ~(|dec_sel);
      swap_q  <= dec_hit & dec_swap;
      cnt_q   <= dec_hit ? dec_wait : 4'd1;
    end else if (state == ACCESS && cnt_q != 4'd0) begin
      cnt_q   <= cnt_q - 4'd1;
    end
  end

  // Read data register, only updated by a completing read
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        rdata_q <= '0;
    else if (rd_done) rdata_q <= swap_q ? swap32(slv_rd) : slv_rd;
  end

  assign m_rdata_o   = rdata_q;
  assign m_ack_o     = (state == DONE);
  assign err_o       = (state == DONE) & err_q;
  assign stall_o     = m_req_i & ~m_ack_o;
  assign s_sel_o     = (state == ACCESS) ? tgt_q : '0;
  assign s_addr_o    = addr_q;
  assign s_wdata_o   = wdata_q;
  assign s_we_o      = (state == ACCESS && |tgt_q) ? we_q : 4'b0000;
  assign con_valid_o = (state == ACCESS) & con_q;
  assign con_char_o  = con_valid_o ? wdata_q[31:24] : 8'h00;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: decode, wait states, swapping,
// console, unmapped access, back-to-back and mid-access reset.
module tb_soc_bus_fabric;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_we;
  logic [31:0] m_rdata;
  logic        m_ack, err, stall;
  logic [2:0]  s_sel;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_we;
  logic [95:0] s_rdata;
  logic        con_valid;
  logic [7:0]  con_char;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  soc_bus_fabric #(.SLV_WAIT(12'h131)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_we_i(m_we),
    .m_rdata_o(m_rdata), .m_ack_o(m_ack),
    .err_o(err), .stall_o(stall),
    .s_sel_o(s_sel), .s_addr_o(s_addr),
    .s_wdata_o(s_wdata), .s_we_o(s_we),
    .s_rdata_i(s_rdata),
    .con_valid_o(con_valid), .con_char_o(con_char)
  );

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w);
    @(posedge clk);
    #1;
    m_req = 1'b1; m_addr = a; m_wdata = d; m_we = w;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({m_rdata, m_ack, err, s_sel, s_addr, s_wdata, s_we, con_valid,
         con_char} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got rdata=%h ack=%b sel=%b we=%b want all 0",
               m_rdata, m_ack, s_sel, s_we);
    end
  endtask

  task automatic test_read_slave0();
    s_rdata[31:0] = 32'h12345678;
    issue(32'h00000010, 32'h0, 4'b0000);
    @(negedge clk);
    n_cmp++;
    if (s_sel !== 3'b001) begin n_fail++;
      $display("FAIL rd0_sel_c1: got %b want 001", s_sel); end
    n_cmp++;
    if (s_addr !== 32'h00000010) begin n_fail++;
      $display("FAIL rd0_addr: got %h want 00000010", s_addr); end
    @(negedge clk);
    n_cmp++;
    if ({s_sel, m_ack} !== 4'b0010) begin n_fail++;
      $display("FAIL rd0_c2: got sel/ack %b want 0010", {s_sel, m_ack}); end
    @(negedge clk);
    n_cmp++;
    if ({m_ack, err, s_sel} !== 5'b10000) begin n_fail++;
      $display("FAIL rd0_ack_c3: got ack/err/sel %b want 10000",
               {m_ack, err, s_sel}); end
    n_cmp++;
    if (m_rdata !== 32'h12345678) begin n_fail++;
      $display("FAIL rd0_data: got %h want 12345678", m_rdata); end
    m_req = 1'b0;
  endtask

  task automatic test_unmapped();
    issue(32'h80000000, 32'h0, 4'b0000);
    @(negedge clk);
    n_cmp++;
    if ({s_sel, s_we} !== 7'b0) begin n_fail++;
      $display("FAIL unm_sel: got sel/we %b want 0", {s_sel, s_we}); end
    @(negedge clk);
    n_cmp++;
    if (m_ack !== 1'b0) begin n_fail++;
      $display("FAIL unm_early_ack: got %b want 0", m_ack); end
    @(negedge clk);
    n_cmp++;
    if ({m_ack, err} !== 2'b11) begin n_fail++;
      $display("FAIL unm_ack_err: got %b want 11", {m_ack, err}); end
    n_cmp++;
    if (m_rdata !== 32'h0) begin n_fail++;
      $display("FAIL unm_data: got %h want 00000000", m_rdata); end
    m_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m_ack, err} !== 2'b00) begin n_fail++;
      $display("FAIL unm_after: got %b want 00", {m_ack, err}); end
  endtask

  task automatic test_swap_read();
    s_rdata[95:64] = 32'hAABBCCDD;
    issue(32'he0000000, 32'h0, 4'b0000);
    @(negedge clk);
    n_cmp++;
    if (s_sel !== 3'b100) begin n_fail++;
      $display("FAIL swr_sel: got %b want 100", s_sel); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({m_ack, err} !== 2'b10) begin n_fail++;
      $display("FAIL swr_ack: got %b want 10", {m_ack, err}); end
    n_cmp++;
    if (m_rdata !== 32'hDDCCBBAA) begin n_fail++;
      $display("FAIL swr_data: got %h want DDCCBBAA", m_rdata); end
    m_req = 1'b0;
  endtask

  task automatic test_swap_write();
    issue(32'he0000004, 32'h11223344, 4'b1100);
    @(negedge clk);
    n_cmp++;
    if ({s_sel, s_we} !== 7'b100_0011) begin n_fail++;
      $display("FAIL sww_c1: got sel/we %b want 1000011", {s_sel, s_we}); end
    n_cmp++;
    if (s_wdata !== 32'h44332211) begin n_fail++;
      $display("FAIL sww_data: got %h want 44332211", s_wdata); end
    @(negedge clk);
    n_cmp++;
    if ({m_ack, err, s_we} !== 6'b10_0000) begin n_fail++;
      $display("FAIL sww_c2: got ack/err/we %b want 100000",
               {m_ack, err, s_we}); end
    n_cmp++;
    if (m_rdata !== 32'hDDCCBBAA) begin n_fail++;
      $display("FAIL sww_rdata_hold: got %h want DDCCBBAA", m_rdata); end
    m_req = 1'b0;
  endtask

  task automatic test_console();
    issue(32'hf00000d0, 32'h41000000, 4'b1000);
    n_cmp++;
    if (con_valid !== 1'b0) begin n_fail++;
      $display("FAIL con_c0: got %b want 0", con_valid); end
    @(negedge clk);
    n_cmp++;
    if ({con_valid, con_char} !== 9'h141) begin n_fail++;
      $display("FAIL con_c1: got valid=%b char=%h want 1/41",
               con_valid, con_char); end
    n_cmp++;
    if ({s_sel, s_we} !== 7'b0) begin n_fail++;
      $display("FAIL con_sel: got %b want 0", {s_sel, s_we}); end
    @(negedge clk);
    n_cmp++;
    if ({con_valid, m_ack, err} !== 3'b010) begin n_fail++;
      $display("FAIL con_c2: got valid/ack/err %b want 010",
               {con_valid, m_ack, err}); end
    m_req = 1'b0;
  endtask

  task automatic test_console_read();
    issue(32'hf00000d0, 32'h0, 4'b0000);
    @(negedge clk);
    n_cmp++;
    if (con_valid !== 1'b0) begin n_fail++;
      $display("FAIL conrd_valid: got %b want 0", con_valid); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({m_ack, err} !== 2'b10 || m_rdata !== 32'h0) begin n_fail++;
      $display("FAIL conrd_ack: got ack/err %b data %h want 10/00000000",
               {m_ack, err}, m_rdata); end
    m_req = 1'b0;
  endtask

  task automatic test_wait_states();
    s_rdata[63:32] = 32'hCAFEF00D;
    issue(32'h40000000, 32'h0, 4'b0000);
    for (int c = 0; c <= 4; c++) begin
      n_cmp++;
      if ({stall, m_ack} !== 2'b10) begin n_fail++;
        $display("FAIL wait_c%0d: got stall/ack %b want 10", c,
                 {stall, m_ack}); end
      if (c > 0) begin
        n_cmp++;
        if (s_sel !== 3'b010) begin n_fail++;
          $display("FAIL wait_sel_c%0d: got %b want 010", c, s_sel); end
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({stall, m_ack} !== 2'b01) begin n_fail++;
      $display("FAIL wait_c5: got stall/ack %b want 01", {stall, m_ack}); end
    n_cmp++;
    if (m_rdata !== 32'hCAFEF00D) begin n_fail++;
      $display("FAIL wait_data: got %h want CAFEF00D", m_rdata); end
    m_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(32'h00000020, 32'hDEADBEEF, 4'b1111);
    @(negedge clk);
    n_cmp++;
    if ({s_sel, s_we} !== 7'b001_1111) begin n_fail++;
      $display("FAIL b2b_c1: got sel/we %b want 0011111", {s_sel, s_we}); end
    n_cmp++;
    if (s_wdata !== 32'hDEADBEEF || s_addr !== 32'h20) begin n_fail++;
      $display("FAIL b2b_bus: got %h@%h want DEADBEEF@00000020",
               s_wdata, s_addr); end
    @(negedge clk);
    n_cmp++;
    if (m_ack !== 1'b1) begin n_fail++;
      $display("FAIL b2b_ack: got %b want 1", m_ack); end
    m_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue(32'h40000010, 32'h0, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (s_sel !== 3'b010) begin n_fail++;
      $display("FAIL rstm_pre: got %b want 010", s_sel); end
    rst = 1'b1;
    m_req = 1'b0;
    #1;
    n_cmp++;
    if ({m_rdata, m_ack, err, stall, s_sel, s_addr, s_wdata, s_we,
         con_valid, con_char} !== '0) begin n_fail++;
      $display("FAIL rstm_async: got rdata=%h ack=%b sel=%b addr=%h want 0",
               m_rdata, m_ack, s_sel, s_addr); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (m_ack !== 1'b0) begin n_fail++;
        $display("FAIL rstm_noack%0d: got %b want 0", c, m_ack); end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(32'h00000030, 32'h0000005A, 4'b0001);
    @(negedge clk);
    n_cmp++;
    if ({s_sel, s_we} !== 7'b001_0001) begin n_fail++;
      $display("FAIL rstm_wr_c1: got %b want 0010001", {s_sel, s_we}); end
    @(negedge clk);
    n_cmp++;
    if (m_ack !== 1'b1) begin n_fail++;
      $display("FAIL rstm_wr_ack: got %b want 1", m_ack); end
    m_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_ack !== 1'b0) begin n_fail++;
      $display("FAIL rstm_wr_idle: got %b want 0", m_ack); end
  endtask

  initial begin
    rst = 1'b1; m_req = 1'b0; m_addr = '0; m_wdata = '0; m_we = '0;
    s_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_read_slave0();
    test_unmapped();
    test_swap_read();
    test_swap_write();
    test_console();
    test_console_read();
    test_wait_states();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_bus_fabric.md
# soc_bus_fabric

Parametrised single-master bus fabric for HF-RISC SoCs. Replaces the fixed boot/RAM/peripheral decode and delay-flag read muxing with a registered request/acknowledge engine. Features: NSLAVES address-tag regions, per-region read wait states, per-region byte-lane swapping, and a built-in simulation console port. Sits between the processor core (via `stall_o`) and the boot ROM, BRAM and peripheral blocks.

## Interface
- `NSLAVES`, 3: number of slave regions, 1..8.
- `SLV_TAG`, 12'he40: packed 4 bits per slave; slave i decodes when `m_addr_i[31:28] == SLV_TAG[4i+3:4i]`.
- `SLV_WAIT`, 12'h111: packed 4 bits per slave; read latency W (0..15) in cycles after select.
- `SLV_SWAP`, 3'b100: bit i set means slave i is byte-reversed on data and write-enable lanes.
- `CONSOLE_ADDR`, 32'hf00000d0: exact-match console write address.
- `clk_i  in  1  clock, rising edge`
- `rst_i  in  1  reset, asynchronous, active-high`
- `m_req_i  in  1  master request, held until ack`
- `m_addr_i  in  32  byte address`
- `m_wdata_i  in  32  write data`
- `m_we_i  in  4  byte write enables; 0000 = read`
- `m_rdata_o  out  32  read data, registered`
- `m_ack_o  out  1  one-cycle completion pulse`
- `err_o  out  1  unmapped-access flag, coincident with ack`
- `stall_o  out  1  m_req_i & ~m_ack_o, combinational`
- `s_sel_o  out  NSLAVES  one-hot slave select`
- `s_addr_o  out  32  registered address`
- `s_wdata_o  out  32  registered, lane-swapped write data`
- `s_we_o  out  4  write enables, lane-swapped`
- `s_rdata_i  in  32*NSLAVES  slave i read data at [32i+31:32i]`
- `con_valid_o  out  1  console character strobe`
- `con_char_o  out  8  console character`

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, `m_req_i`=1:
  - Capture addr, wdata, we.
  - Decode with priority: console (exact addr, we≠0) > lowest-index tag match > unmapped.
  - Load the wait counter with W of the target; go to ACCESS.
- ACCESS:
  - `s_sel_o` one-hot asserted for the whole state (zero for console/unmapped).
  - `s_addr_o` = captured address.
  - Write: `s_we_o` asserted for the first ACCESS cycle only, then go to DONE (W ignored).
  - Read: count down W. At the edge where the counter is 0, sample `s_rdata_i` slice into `m_rdata_o` and go to DONE.
- Swap, when `SLV_SWAP[i]` is set:
  - `s_wdata_o` = {wd[7:0],wd[15:8],wd[23:16],wd[31:24]}.
  - `s_we_o` = bit-reversed we.
  - Captured read data is byte-reversed.
- Console write: `con_valid_o` pulses in the first ACCESS cycle with `con_char_o` = wdata[31:24]; completes as a write. A console-address read returns 0 with no error.
- Unmapped access: no select and no write. A read loads `m_rdata_o` = 0; `err_o` = 1 in DONE.
- DONE: `m_ack_o` = 1 for one cycle, then always return to IDLE. `m_req_i` in DONE is ignored; the master presents its next request after ack.
- `m_rdata_o` holds its value until the next read capture; writes do not alter it.

## Timing
- Request sampled in IDLE at cycle 0.
- Write: ACCESS is cycle 1; ack in cycle 2.
- Read with latency W: ACCESS spans cycles 1..1+W; data sampled at the end of cycle 1+W; ack and valid `m_rdata_o` in cycle 2+W.
- Minimum request-to-request spacing is 3 cycles (write) or 3+W cycles (read).
- Reset values: all outputs 0; FSM in IDLE; counter 0.
- Reset during ACCESS or DONE: immediate return to IDLE; select and enables drop asynchronously; no ack issued; the interrupted access is lost.
- Duplicate tags: the lowest index wins; other slaves are never selected.

## Test plan
- Read `0x00000010`, slave0 returns `0x12345678`, W=1 → `s_sel_o`=001 in cycles 1–2; ack in cycle 3; `m_rdata_o`=`0x12345678`; `err_o`=0.
- Slave2 (`0xe…`) read with `s_rdata_i` slice `0xAABBCCDD` → `m_rdata_o`=`0xDDCCBBAA`. Write `0x11223344` with we=1100 → `s_wdata_o`=`0x44332211`, `s_we_o`=0011 for one cycle; ack in cycle 2.
- Write `0x41000000` to `0xf00000d0` → `con_valid_o` high for one cycle in cycle 1 with `con_char_o`=`0x41`; `s_sel_o`=0; ack in cycle 2.
- Read `0x80000000` → no select; ack in cycle 3 (W=1 path) with `err_o`=1 and `m_rdata_o`=0.
- Override `SLV_WAIT`=12'h131 and read slave1 → ack in cycle 5; `stall_o` high in cycles 0–4 and low in cycle 5. A second request issued right after ack is accepted in the following IDLE cycle.
- Assert `rst_i` in cycle 2 of a W=3 read → all outputs 0 immediately; no ack. After release, a new write completes normally in 3 cycles.
